// File: rtl/qu_common_pkg.sv
// ---------------------------------------------------------------------------
// qu_common: shared defaults for the rename/issue slice.
//   PHY_RF_DEPTH       number of physical registers
//   PHY_RF_ADDR_WIDTH  physical register index width
//   NUM_WB_PORTS       writeback clear ports
//   NUM_RD_PORTS       issue-side busy read ports
//   phyreg_addr_t      physical register index, shared with the map stage
// ---------------------------------------------------------------------------
package qu_common;

  localparam int PHY_RF_DEPTH      = 128;
  localparam int PHY_RF_ADDR_WIDTH = $clog2(PHY_RF_DEPTH);
  localparam int NUM_WB_PORTS      = 2;
  localparam int NUM_RD_PORTS      = 4;

  typedef logic [PHY_RF_ADDR_WIDTH-1:0] phyreg_addr_t;

endpackage

// File: rtl/busy_table_if.sv
// ---------------------------------------------------------------------------
// busy_table_if: busy-table write interface from the map stage.
//   en                  map-stage enable (qualifies the write only)
//   busy_table_wr_en    write strobe
//   busy_table_wr_addr  physical register being allocated/freed
//   busy_table_data_in  1 = mark busy, 0 = mark free
// Modports: master = map stage, slave = busy table.
// ---------------------------------------------------------------------------
interface busy_table_if #(
  parameter int ADDR_W = qu_common::PHY_RF_ADDR_WIDTH
);

  logic              en;
  logic              busy_table_wr_en;
  logic [ADDR_W-1:0] busy_table_wr_addr;
  logic              busy_table_data_in;

  modport master (
    output en, busy_table_wr_en, busy_table_wr_addr, busy_table_data_in
  );

  modport slave (
    input en, busy_table_wr_en, busy_table_wr_addr, busy_table_data_in
  );

endinterface

// File: rtl/busy_table_checker.sv
// ---------------------------------------------------------------------------
// busy_table_checker: sticky protocol-error flag for the busy table.
// Built only when QU_BUSY_TABLE_CHECK_EN is defined.
//   clk, rst   clock, synchronous active-high reset (clears err)
//   bits       current table contents
//   set_eff    effective map write this cycle; set_addr / set_data its payload
//   clr_eff    per-port effective writeback clear; clr_addr per-port address
//   err        sticky error: set-of-busy, clear-of-free (not also set),
//              or two clear ports naming one address
// ---------------------------------------------------------------------------
module busy_table_checker #(
  parameter int PHY_RF_DEPTH      = qu_common::PHY_RF_DEPTH,
  parameter int PHY_RF_ADDR_WIDTH = $clog2(PHY_RF_DEPTH),
  parameter int NUM_WB_PORTS      = qu_common::NUM_WB_PORTS
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [PHY_RF_DEPTH-1:0]                       bits,
  input  logic                                          set_eff,
  input  logic [PHY_RF_ADDR_WIDTH-1:0]                  set_addr,
  input  logic                                          set_data,
  input  logic [NUM_WB_PORTS-1:0]                       clr_eff,
  input  logic [NUM_WB_PORTS-1:0][PHY_RF_ADDR_WIDTH-1:0] clr_addr,
  output logic                                          err
);

  logic hit;

  always_comb begin
    hit = set_eff && set_data && bits[set_addr];
    for (int i = 0; i < NUM_WB_PORTS; i++) begin
      // A clear of a free bit is legal when the map stage re-allocates it
      // in the same cycle.
      if (clr_eff[i] && !bits[clr_addr[i]] &&
          !(set_eff && set_data && (set_addr == clr_addr[i])))
        hit = 1'b1;
      for (int k = 0; k < i; k++) begin
        if (clr_eff[i] && clr_eff[k] && (clr_addr[i] == clr_addr[k]))
          hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)      err <= 1'b0;
    else if (hit) err <= 1'b1;
  end

endmodule

// File: rtl/busy_table.sv
// ---------------------------------------------------------------------------
// busy_table: physical-register busy table (1 = result pending).
//   clk, rst     clock, synchronous active-high reset
//   map          busy_table_if.slave, map-stage write (set/free one entry)
//   flush        clears the whole table at the next edge
//   wb_clr_en    per-port writeback clear strobe (not gated by map.en)
//   wb_clr_addr  per-port register to clear
//   rd_addr      issue-side read addresses
//   rd_busy      combinational busy bits, writeback clears bypassed
//   busy_count   registered number of busy entries
//   err          sticky protocol error; only with QU_BUSY_TABLE_CHECK_EN
// Optional feature macro: QU_BUSY_TABLE_CHECK_EN.
// Edge priority: rst > flush > map write > writeback clear.
// ---------------------------------------------------------------------------
module busy_table #(
  parameter  int PHY_RF_DEPTH      = qu_common::PHY_RF_DEPTH,
  parameter  int PHY_RF_ADDR_WIDTH = $clog2(PHY_RF_DEPTH),
  parameter  int NUM_WB_PORTS      = qu_common::NUM_WB_PORTS,
  parameter  int NUM_RD_PORTS      = qu_common::NUM_RD_PORTS,
  localparam int CNT_W             = $clog2(PHY_RF_DEPTH + 1)
) (
  input  logic                                          clk,
  input  logic                                          rst,
  busy_table_if.slave                                   map,
  input  logic                                          flush,
  input  logic [NUM_WB_PORTS-1:0]                       wb_clr_en,
  input  logic [NUM_WB_PORTS-1:0][PHY_RF_ADDR_WIDTH-1:0] wb_clr_addr,
  input  logic [NUM_RD_PORTS-1:0][PHY_RF_ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD_PORTS-1:0]                       rd_busy,
  output logic [CNT_W-1:0]                              busy_count,
  output logic                                          err
);

  // Addresses past the last register only exist for non-power-of-2 depths.
  function automatic logic in_range(input logic [PHY_RF_ADDR_WIDTH-1:0] a);
    return int'(a) < PHY_RF_DEPTH;
  endfunction

  logic [PHY_RF_DEPTH-1:0] bits_q, bits_d, clr_mask;
  logic [NUM_WB_PORTS-1:0] clr_eff;
  logic                    set_eff, rise;
  logic [CNT_W-1:0]        n_fall, count_d;
  logic                    dup;

  // Effective writes and the one-hot mask of entries cleared this cycle.
  always_comb begin
    // NOTE: every variable driven here gets a default first, otherwise a
    // path that skips the assignment infers a latch.
    set_eff  = map.en && map.busy_table_wr_en && in_range(map.busy_table_wr_addr);
    clr_eff  = '0;
    clr_mask = '0;
    for (int i = 0; i < NUM_WB_PORTS; i++) begin
      clr_eff[i] = wb_clr_en[i] && in_range(wb_clr_addr[i]);
      if (clr_eff[i]) clr_mask[wb_clr_addr[i]] = 1'b1;
    end
  end

  // Next table state: clears first, then the map write overrides them.
  always_comb begin
    bits_d = bits_q & ~clr_mask;
    if (set_eff) bits_d[map.busy_table_wr_addr] = map.busy_table_data_in;
    if (flush)   bits_d = '0;
  end

  // Incremental count. At most one entry can rise (the map write); falls
  // come from a map free or from distinct clear addresses the map write
  // does not also target.
  always_comb begin
    rise   = set_eff && map.busy_table_data_in && !bits_q[map.busy_table_wr_addr];
    n_fall = '0;
    if (set_eff && !map.busy_table_data_in && bits_q[map.busy_table_wr_addr])
      n_fall = n_fall + CNT_W'(1);
    for (int i = 0; i < NUM_WB_PORTS; i++) begin
      dup = 1'b0;
      for (int k = 0; k < i; k++)
        if (clr_eff[k] && (wb_clr_addr[k] == wb_clr_addr[i])) dup = 1'b1;
      if (clr_eff[i] && !dup && bits_q[wb_clr_addr[i]] &&
          !(set_eff && (map.busy_table_wr_addr == wb_clr_addr[i])))
        n_fall = n_fall + CNT_W'(1);
    end
    count_d = flush ? '0 : busy_count + CNT_W'(rise) - n_fall;
  end

  // NOTE: the table is a flop array rather than a RAM, so it can and must
  // be reset; a RAM would need an explicit clearing sequence instead.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      bits_q     <= '0;
      busy_count <= '0;
    end else begin
      bits_q     <= bits_d;
      busy_count <= count_d;
    end
  end

  // Reads see the stored bit with same-cycle writeback clears bypassed;
  // a same-cycle map write is deliberately not forwarded.
  always_comb begin
    rd_busy = '0;
    for (int j = 0; j < NUM_RD_PORTS; j++)
      rd_busy[j] = in_range(rd_addr[j]) && bits_q[rd_addr[j]] && !clr_mask[rd_addr[j]];
  end

`ifdef QU_BUSY_TABLE_CHECK_EN
  busy_table_checker #(
    .PHY_RF_DEPTH      (PHY_RF_DEPTH),
    .PHY_RF_ADDR_WIDTH (PHY_RF_ADDR_WIDTH),
    .NUM_WB_PORTS      (NUM_WB_PORTS)
  ) u_checker (
    .clk      (clk),
    .rst      (rst),
    .bits     (bits_q),
    .set_eff  (set_eff),
    .set_addr (map.busy_table_wr_addr),
    .set_data (map.busy_table_data_in),
    .clr_eff  (clr_eff),
    .clr_addr (wb_clr_addr),
    .err      (err)
  );
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/busy_table.md
Name: busy_table

Overview:
- Physical-register busy table: one bit per physical register; 1 = result pending, 0 = value available.
- Receiving end of the busy-table write interface driven by the map stage. The map stage sets a bit when it allocates a destination physical register.
- Writeback clears bits as results are produced.
- Issue/reservation logic reads the bits to decide operand readiness.

Parameters:
- PHY_RF_DEPTH, 128, number of physical registers; PHY_RF_ADDR_WIDTH = $clog2(PHY_RF_DEPTH).
- NUM_WB_PORTS, 2, number of independent writeback clear ports.
- NUM_RD_PORTS, 4, number of combinational busy-read ports.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- en  in  1  map-stage enable; qualifies the set port only
- busy_table_wr_en  in  1  write strobe from the map stage
- busy_table_wr_addr  in  PHY_RF_ADDR_WIDTH  physical register addressed by the map stage
- busy_table_data_in  in  1  value written (1 = mark busy, 0 = mark free)
- flush  in  1  pipeline flush; clears whole table
- wb_clr_en  in  NUM_WB_PORTS  per-port writeback clear strobe
- wb_clr_addr  in  NUM_WB_PORTS x PHY_RF_ADDR_WIDTH  per-port physical register to clear
- rd_addr  in  NUM_RD_PORTS x PHY_RF_ADDR_WIDTH  issue-side read addresses
- rd_busy  out  NUM_RD_PORTS  busy bit per read port
- busy_count  out  $clog2(PHY_RF_DEPTH+1)  number of busy entries (registered)
- err  out  1  sticky protocol error (QU_BUSY_TABLE_CHECK_EN only; tied 0 otherwise)

Behaviour:
- Reset (rst=1 at posedge): all table bits 0, busy_count 0, err 0. Reset mid-operation discards any same-cycle set, clear or flush.
- Map write is effective when en && busy_table_wr_en. It writes busy_table_data_in to the addressed bit at the next posedge.
- Clear port i is effective when wb_clr_en[i]=1. It writes 0 to bit wb_clr_addr[i] at the next posedge.
- Clear ports are not gated by en.
- Priority at one posedge, for the same address: rst > flush > map write > writeback clear.
  - A set and a clear to the same address in one cycle leaves the bit 1.
  - Duplicate clears to one address in one cycle are equivalent to a single clear.
- flush=1: every bit 0 and busy_count 0 at the next posedge; set and clears that cycle are ignored.
- Read ports are combinational, zero latency:
  - rd_busy[j] = stored bit AND NOT (any effective clear to rd_addr[j] this cycle). Writeback is bypassed.
  - A same-cycle map write is NOT forwarded; it is visible from the next cycle.
  - During a flush cycle, rd_busy still shows the stored state with clear bypass applied.
- busy_count is updated incrementally, not by a full popcount:
  - next = current + (bits going 0->1) - (bits going 1->0).
  - Only actual state changes count, so a redundant set or clear leaves the count unchanged.
  - Invariant: busy_count always equals the popcount of the table. Range 0..PHY_RF_DEPTH; no wrap.
- Out-of-range addresses (>= PHY_RF_DEPTH, when the depth is not a power of 2) are ignored on writes; reads return 0.

Optional Feature:
- Macro QU_BUSY_TABLE_CHECK_EN.
- When defined, err is set (sticky until rst) at the posedge following any of:
  - an effective map write of 1 to an already-busy bit;
  - an effective clear of an already-free bit, not also set that cycle;
  - two clear ports naming the same address in one cycle.
- The table update itself is unchanged by err.
- When undefined, the checker logic is absent and err is constant 0.

Decomposition:
- Shared package qu_common holds:
  - PHY_RF_DEPTH / PHY_RF_ADDR_WIDTH defaults;
  - a phyreg_addr_t typedef, shared with the map stage;
  - NUM_WB_PORTS default.
- One natural sub-module, busy_table_checker. It holds the QU_BUSY_TABLE_CHECK_EN error logic and is instantiated under the macro.
- Clear-bypass and count-delta logic stay inline.

Test Plan:
- Reset, then map write addr=5 data=1 with en=1 -> next cycle rd_busy for addr 5 = 1, busy_count=1; in the write cycle itself, rd_busy for addr 5 = 0.
- Addr 5 busy; wb_clr_en[0]=1 addr=5 -> rd_busy for addr 5 = 0 in the same cycle (bypass), bit 0 and busy_count=0 next cycle.
- Same cycle: map write addr=7 data=1 and wb clear addr=7 -> bit 7 = 1 next cycle; busy_count +1. With QU_BUSY_TABLE_CHECK_EN and bit 7 already free, err stays 0.
- Map write addr=9 with en=0 -> no change, busy_count unchanged. Concurrent clear of busy addr 3 with en=0 -> still applied.
- Set addrs 1, 2, 3 over 3 cycles, then flush together with a set of addr 4 -> all bits 0 and busy_count=0 next cycle; addr 4 not busy.
- With QU_BUSY_TABLE_CHECK_EN: set addr 10 twice -> err=1 after the second posedge and stays 1 until rst; busy_count=1.
